// File: rtl/rr_psel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_psel_pkg
// Description : Shared types and helpers for the multi-grant round-robin
//               selector (slot record, wrapped increment, one-hot decode).
// Revision    : 1.0 - initial release
// ============================================================================
package rr_psel_pkg;

    localparam int c_max_width = 256;
    localparam int c_max_idx_w = 8;

    // Held grant for one slot; idx is sized for the largest supported WIDTH.
    typedef struct packed {
        logic                   valid;
        logic [c_max_idx_w-1:0] idx;
    } slot_t;

    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned w);
        return (p + 32'd1 >= w) ? 32'd0 : p + 32'd1;
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [c_max_width-1:0] oh);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 0; i < c_max_width; i++) begin
            if (oh[i]) begin
                r = r | i;
            end
        end
        return r;
    endfunction

endpackage : rr_psel_pkg
`default_nettype wire

// File: rtl/rr_first_sel.sv
`default_nettype none
// ============================================================================
// Module      : rr_first_sel
// Description : Combinational circular first-set finder starting at 'start'.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_first_sel
    import rr_psel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    input  logic [IDX_W-1:0] start,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        logic [IDX_W-1:0] p;
        p      = start;
        onehot = '0;
        found  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && mask[p]) begin
                onehot[p] = 1'b1;
                found     = 1'b1;
            end
            p = IDX_W'(wrap_inc(32'(p), WIDTH));
        end
        idx = IDX_W'(onehot_to_idx(c_max_width'(onehot)));
    end

endmodule : rr_first_sel
`default_nettype wire

// File: rtl/rr_psel_multi.sv
`default_nettype none
// ============================================================================
// Module      : rr_psel_multi
// Description : Registered multi-grant round-robin selector with per-slot
//               valid/ready hold. Optional aging: define RR_PSEL_AGING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_psel_multi
    import rr_psel_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int REQS      = 2,
    parameter  int AGE_LIMIT = 15,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        req,
    input  logic [REQS-1:0]         gnt_ready,
    output logic [REQS-1:0]         gnt_valid,
    output logic [REQS*IDX_W-1:0]   gnt_idx,
    output logic [REQS*WIDTH-1:0]   gnt_bus,
    output logic [WIDTH-1:0]        gnt,
    output logic [WIDTH-1:0]        gnt_fire,
    output logic                    empty,
    output logic [IDX_W-1:0]        ptr
);

    slot_t [REQS-1:0]  r_slot;
    slot_t [REQS-1:0]  w_nxt_slot;
    logic [IDX_W-1:0]  r_ptr;

    logic [REQS-1:0]   w_free;
    logic [WIDTH-1:0]  w_held;
    logic [WIDTH-1:0]  w_fire;
    logic [WIDTH-1:0]  w_elig;
    logic [WIDTH-1:0]  w_aged;
    logic [WIDTH-1:0]  w_new_oh;
    logic              w_any_new;
    logic [IDX_W-1:0]  w_last_idx;
    logic [IDX_W:0]    w_ptr_ext;
    logic [IDX_W-1:0]  w_ptr_nxt;

    logic [WIDTH-1:0]  w_taken     [REQS];
    logic [WIDTH-1:0]  w_stage_msk [REQS];
    logic [WIDTH-1:0]  w_pick_oh   [REQS];
    logic [IDX_W-1:0]  w_pick_idx  [REQS];
    logic [REQS-1:0]   w_pick_found;

    // Upper idx bits of the shared slot record are never populated here.
    logic              w_unused_slot;
    assign w_unused_slot = ^r_slot;

    // Held includes slots firing this cycle so a fired requester is not re-granted.
    always_comb begin
        w_held = '0;
        w_fire = '0;
        for (int k = 0; k < REQS; k++) begin
            if (r_slot[k].valid) begin
                w_held[r_slot[k].idx[IDX_W-1:0]] = 1'b1;
                if (gnt_ready[k]) begin
                    w_fire[r_slot[k].idx[IDX_W-1:0]] = 1'b1;
                end
            end
        end
    end

    assign w_elig = req & ~w_held;

    for (genvar k = 0; k < REQS; k++) begin : g_slot
        assign w_free[k]                  = ~r_slot[k].valid | gnt_ready[k];
        assign gnt_valid[k]               = r_slot[k].valid;
        assign gnt_idx[k*IDX_W +: IDX_W]  = r_slot[k].idx[IDX_W-1:0];
        assign gnt_bus[k*WIDTH +: WIDTH]  = r_slot[k].valid
                                          ? (WIDTH'(1) << r_slot[k].idx[IDX_W-1:0])
                                          : '0;
    end

    // Each stage scans aged requesters first, then falls back to all eligible.
    for (genvar n = 0; n < REQS; n++) begin : g_stage
        if (n == 0) begin : g_first
            assign w_taken[n] = '0;
        end else begin : g_next
            assign w_taken[n] = w_taken[n-1] | w_pick_oh[n-1];
        end

        assign w_stage_msk[n] = (|(w_aged & ~w_taken[n])) ? (w_aged & ~w_taken[n])
                                                          : (w_elig & ~w_taken[n]);

        rr_first_sel #(
            .WIDTH  (WIDTH),
            .IDX_W  (IDX_W)
        ) u_first_sel (
            .mask   (w_stage_msk[n]),
            .start  (r_ptr),
            .onehot (w_pick_oh[n]),
            .idx    (w_pick_idx[n]),
            .found  (w_pick_found[n])
        );
    end

    // n-th pick lands in the n-th free slot, in ascending slot order.
    always_comb begin
        int rank;
        rank       = 0;
        w_nxt_slot = r_slot;
        w_new_oh   = '0;
        w_any_new  = 1'b0;
        w_last_idx = '0;
        for (int k = 0; k < REQS; k++) begin
            if (w_free[k]) begin
                w_nxt_slot[k].valid = 1'b0;
                w_nxt_slot[k].idx   = '0;
                for (int n = 0; n < REQS; n++) begin
                    if (n == rank && w_pick_found[n]) begin
                        w_nxt_slot[k].valid = 1'b1;
                        w_nxt_slot[k].idx   = c_max_idx_w'(w_pick_idx[n]);
                        w_new_oh            = w_new_oh | w_pick_oh[n];
                        w_any_new           = 1'b1;
                        w_last_idx          = w_pick_idx[n];
                    end
                end
                rank = rank + 1;
            end
        end
    end

    // Explicit wrap so non-power-of-two WIDTH works.
    assign w_ptr_ext = {1'b0, w_last_idx} + 1'b1;
    assign w_ptr_nxt = (w_ptr_ext >= (IDX_W+1)'(WIDTH)) ? '0 : w_ptr_ext[IDX_W-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_slot <= '0;
            r_ptr  <= '0;
        end else begin
            r_slot <= w_nxt_slot;
            if (w_any_new) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef RR_PSEL_AGING_EN
    localparam int                 c_age_w   = $clog2(AGE_LIMIT + 1);
    localparam logic [c_age_w-1:0] c_age_max = c_age_w'(AGE_LIMIT);

    logic [c_age_w-1:0] r_age [WIDTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!req[i] || w_new_oh[i]) begin
                    r_age[i] <= '0;
                end else if (w_elig[i] && r_age[i] != c_age_max) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_aged = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_aged[i] = w_elig[i] & (r_age[i] == c_age_max);
        end
    end
`else
    localparam int c_unused_age_limit = AGE_LIMIT;
    assign w_aged = '0;
`endif

    assign gnt      = w_held;
    assign gnt_fire = w_fire;
    assign empty    = ~|req;
    assign ptr      = r_ptr;

endmodule : rr_psel_multi
`default_nettype wire

// File: tb/tb_rr_psel_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_psel_multi
// Description : Scoreboard bench for rr_psel_multi against a list-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_psel_multi;

    localparam int WIDTH     = 8;
    localparam int REQS      = 2;
    localparam int AGE_LIMIT = 3;
    localparam int IDX_W     = 3;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [WIDTH-1:0]      req = '0;
    logic [REQS-1:0]       gnt_ready = '0;
    logic [REQS-1:0]       gnt_valid;
    logic [REQS*IDX_W-1:0] gnt_idx;
    logic [REQS*WIDTH-1:0] gnt_bus;
    logic [WIDTH-1:0]      gnt;
    logic [WIDTH-1:0]      gnt_fire;
    logic                  empty;
    logic [IDX_W-1:0]      ptr;

    always #5 clock = ~clock;

    rr_psel_multi #(
        .WIDTH     (WIDTH),
        .REQS      (REQS),
        .AGE_LIMIT (AGE_LIMIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt_ready (gnt_ready),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_bus   (gnt_bus),
        .gnt       (gnt),
        .gnt_fire  (gnt_fire),
        .empty     (empty),
        .ptr       (ptr)
    );

    typedef struct {
        logic [REQS-1:0]       valid;
        logic [REQS*WIDTH-1:0] bus;
        logic [REQS*IDX_W-1:0] idx;
        logic [WIDTH-1:0]      gnt;
        logic [IDX_W-1:0]      ptr;
        logic [WIDTH-1:0]      fire;
        logic                  empty;
        bit                    idx_zero;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: slot contents, pointer and wait ages as plain ints.
    bit m_valid [REQS];
    int m_idx   [REQS];
    int m_ptr;
    int m_age   [WIDTH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < REQS; k++) begin
            m_valid[k] = 1'b0;
            m_idx[k]   = 0;
        end
        for (int i = 0; i < WIDTH; i++) m_age[i] = 0;
        m_ptr = 0;
    endfunction

    function automatic bit is_aged(input int i);
`ifdef RR_PSEL_AGING_EN
        return m_age[i] == AGE_LIMIT;
`else
        return (i < 0);
`endif
    endfunction

    function automatic exp_t build_exp(input logic [WIDTH-1:0] r, input logic [REQS-1:0] rdy);
        exp_t e;
        e.valid = '0; e.bus = '0; e.idx = '0; e.gnt = '0; e.fire = '0;
        for (int k = 0; k < REQS; k++) begin
            if (m_valid[k]) begin
                e.valid[k]                 = 1'b1;
                e.bus[k*WIDTH + m_idx[k]]  = 1'b1;
                e.gnt[m_idx[k]]            = 1'b1;
                e.idx[k*IDX_W +: IDX_W]    = IDX_W'(m_idx[k]);
                if (rdy[k]) e.fire[m_idx[k]] = 1'b1;
            end
        end
        e.ptr      = IDX_W'(m_ptr);
        e.empty    = (r == '0);
        e.idx_zero = 1'b0;
        return e;
    endfunction

    function automatic void model_step(input logic [WIDTH-1:0] r, input logic [REQS-1:0] rdy);
        bit held    [WIDTH];
        bit granted [WIDTH];
        int picks[$];
        int last;
        bit any;
        int i;
        any  = 1'b0;
        last = 0;
        for (int j = 0; j < WIDTH; j++) begin
            held[j]    = 1'b0;
            granted[j] = 1'b0;
        end
        for (int k = 0; k < REQS; k++) if (m_valid[k]) held[m_idx[k]] = 1'b1;
        // Aged requesters first, then everyone else, each in circular order.
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < WIDTH; j++) begin
                i = (m_ptr + j) % WIDTH;
                if (r[i] && !held[i] && (is_aged(i) == (pass == 0))) picks.push_back(i);
            end
        end
        for (int k = 0; k < REQS; k++) begin
            if (!m_valid[k] || rdy[k]) begin
                if (picks.size() > 0) begin
                    m_idx[k]   = picks.pop_front();
                    m_valid[k] = 1'b1;
                    granted[m_idx[k]] = 1'b1;
                    last = m_idx[k];
                    any  = 1'b1;
                end else begin
                    m_valid[k] = 1'b0;
                end
            end
        end
        if (any) m_ptr = (last + 1) % WIDTH;
        for (int j = 0; j < WIDTH; j++) begin
            if (!r[j] || granted[j]) m_age[j] = 0;
            else if (!held[j] && m_age[j] < AGE_LIMIT) m_age[j]++;
        end
    endfunction

    task automatic cycle(input logic [WIDTH-1:0] r, input logic [REQS-1:0] rdy,
                         output logic [WIDTH-1:0] fired);
        exp_t e;
        @(posedge clock);
        #1;
        reset     = 1'b1;
        req       = r;
        gnt_ready = rdy;
        e = build_exp(r, rdy);
        fired = e.fire;
        sb.push_back(e);
        model_step(r, rdy);
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] r);
        exp_t e;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req       = r;
        gnt_ready = '1;
        model_reset();
        e = build_exp(r, '1);
        e.idx_zero = 1'b1;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per presented cycle and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("gnt_valid", 64'(gnt_valid), 64'(e.valid));
                check("gnt_bus",   64'(gnt_bus),   64'(e.bus));
                check("gnt",       64'(gnt),       64'(e.gnt));
                check("ptr",       64'(ptr),       64'(e.ptr));
                check("gnt_fire",  64'(gnt_fire),  64'(e.fire));
                check("empty",     64'(empty),     64'(e.empty));
                for (int k = 0; k < REQS; k++) begin
                    if (e.valid[k]) check("gnt_idx", 64'(gnt_idx[k*IDX_W +: IDX_W]),
                                          64'(e.idx[k*IDX_W +: IDX_W]));
                end
                if (e.idx_zero) check("reset_idx", 64'(gnt_idx), 64'd0);
                if (gnt_valid == 2'b11)
                    check("dup_slot", 64'(gnt_idx[0 +: IDX_W] == gnt_idx[IDX_W +: IDX_W]), 64'd0);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] fired;
        logic [WIDTH-1:0] rq;
        logic [REQS-1:0]  rdy;

        model_reset();
        do_reset('0);
        cycle(8'b0011_0110, 2'b11, fired);
        cycle(8'b0011_0000, 2'b11, fired);
        cycle(8'b1000_0010, 2'b11, fired);
        cycle(8'b0000_0000, 2'b11, fired);

        do_reset('0);
        cycle(8'b0011_0110, 2'b11, fired);
        cycle(8'b0011_0000, 2'b11, fired);
        cycle(8'b0001_1000, 2'b01, fired);
        cycle(8'b0001_1000, 2'b00, fired);
        cycle(8'b0001_1000, 2'b00, fired);

        // Reset while both slots hold grants, then release with no requests.
        do_reset(8'b0001_1000);
        cycle(8'b0000_0000, 2'b11, fired);
        cycle(8'b0000_0000, 2'b11, fired);

        // Random traffic obeying the hold-until-fire, drop-next-cycle contract.
        rq = '0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < REQS; k++) rdy[k] = ($urandom_range(0, 3) != 0);
            cycle(rq, rdy, fired);
            for (int i = 0; i < WIDTH; i++) begin
                if (fired[i])     rq[i] = 1'b0;
                else if (!rq[i])  rq[i] = ($urandom_range(0, 2) != 0);
            end
        end
        cycle('0, 2'b11, fired);

        repeat (3) @(posedge clock);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rr_psel_multi
`default_nettype wire
